data_memory_bridge: RTL and testbench

- Parametrised, multi-cycle data memory interface between the core load/store unit and a synchronous byte-enabled RAM.
- Uses a valid/ready request handshake and a one-cycle response pulse.
- Accesses that straddle a word boundary are split into two back-to-back memory beats; the read beats are merged, realigned and sign- or zero-extended.
- Out-of-range and invalid-format accesses return an error and never touch the memory.

---
 rtl/data_memory_bridge.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_data_memory_bridge.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_bridge.sv
// data_memory_bridge: multi-cycle bridge between the load/store unit and a
// synchronous byte-enabled RAM. Word-straddling accesses are split into two
// back-to-back beats, and the read beats are merged, realigned and extended.
// Optional build macro: DATA_MISALIGNED_TRAP_EN. When it is defined, a
// misaligned access returns an error instead of being split, and the second
// beat is not built.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high. req_ready is high only in IDLE and low during
// reset. The bridge answers every accepted request with one resp_valid pulse.
// There is no response backpressure: the requester must take the pulse in
// the cycle it appears.
module data_memory_bridge #(
    parameter logic [31:0] DATA_BEGIN  = 32'h10010000,
    parameter logic [31:0] DATA_END    = 32'h1001FFFF,
    parameter int          ADDR_WIDTH  = 14,
    parameter int          MEM_LATENCY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [2:0]            req_format,
    input  logic [31:0]           req_address,
    input  logic [31:0]           req_write_data,
    output logic                  resp_valid,
    output logic [31:0]           resp_data,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [3:0]            mem_byteena,
    output logic                  mem_wren,
    output logic [31:0]           mem_data,
    input  logic [31:0]           mem_q,
    output logic [2:0]            debug_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_BEAT0 = 3'd1,
        S_BEAT1 = 3'd2,
        S_WAIT  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Request decode, evaluated on the incoming request fields
    logic [2:0]            size_m1;
    logic [7:0]            mask_base;
    logic [32:0]           last_addr;
    logic [31:0]           rel_addr;
    logic                  misaligned;
    logic                  acc_err;
    logic [7:0]            acc_mask;
    logic [63:0]           acc_wide;
    logic [ADDR_WIDTH-1:0] acc_word;
    logic                  accept;

    // Latched request
    logic                  wr_q;
    logic [2:0]            fmt_q;
    logic [1:0]            off_q;
    logic [ADDR_WIDTH-1:0] word_q;
    logic [7:0]            mask_q;
    logic [63:0]           wide_q;
    logic                  err_q;
    logic                  split_q;

    // Read-return tracking: one tag per beat in flight, MEM_LATENCY deep
    logic [MEM_LATENCY-1:0] pipe_v;
    logic [MEM_LATENCY-1:0] pipe_b;
    logic                   issue;
    logic                   tail_v;
    logic                   tail_b;
    logic [31:0]            q_beat0;
    logic [31:0]            q_beat1;

    // Load result path
    logic [63:0] q_wide;
    logic [31:0] q_lo;
    logic [31:0] load_result;

    logic unused_bits;

    // Size decode: size minus one and the unshifted lane pattern
    always_comb begin
        size_m1   = 3'd3;
        mask_base = 8'h0F;
        case (req_format[1:0])
            2'b00: begin
                size_m1   = 3'd0;
                mask_base = 8'h01;
            end
            2'b01: begin
                size_m1   = 3'd1;
                mask_base = 8'h03;
            end
            default: begin
                size_m1   = 3'd3;
                mask_base = 8'h0F;
            end
        endcase
    end

    // Last touched byte is computed in 33 bits so a wrap past 2^32 still
    // reads as out of range.
    assign last_addr = {1'b0, req_address} + {30'b0, size_m1};
    assign rel_addr  = req_address - DATA_BEGIN;
    assign acc_word  = rel_addr[ADDR_WIDTH+1:2];
    assign acc_mask  = mask_base << req_address[1:0];
    assign acc_wide  = {32'b0, req_write_data} << {req_address[1:0], 3'b000};

`ifdef DATA_MISALIGNED_TRAP_EN
    assign misaligned = ((req_format[1:0] == 2'b01) && req_address[0]) ||
                        ((req_format[1:0] == 2'b10) && (req_address[1:0] != 2'b00));
    assign split_q    = 1'b0;
`else
    assign misaligned = 1'b0;
    assign split_q    = |mask_q[7:4];
`endif

    assign acc_err = (req_format[1:0] == 2'b11) ||
                     (req_address < DATA_BEGIN) ||
                     (last_addr > {1'b0, DATA_END}) ||
                     misaligned;

    assign accept = (state == S_IDLE) && req_valid;
    assign issue  = ((state == S_BEAT0) || (state == S_BEAT1)) && !wr_q;
    assign tail_v = pipe_v[MEM_LATENCY-1];
    assign tail_b = pipe_b[MEM_LATENCY-1];

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Latch all request fields and the decoded access on acceptance
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_q   <= 1'b0;
            fmt_q  <= 3'b0;
            off_q  <= 2'b0;
            word_q <= '0;
            mask_q <= 8'b0;
            wide_q <= 64'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            wr_q   <= req_write;
            fmt_q  <= req_format;
            off_q  <= req_address[1:0];
            word_q <= acc_word;
            mask_q <= acc_mask;
            wide_q <= acc_wide;
            err_q  <= acc_err;
        end
    end

    // Shift a valid/beat tag along with each read beat until its data returns
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_v <= '0;
            pipe_b <= '0;
        end else begin
            pipe_v[0] <= issue;
            pipe_b[0] <= (state == S_BEAT1);
            for (int i = 1; i < MEM_LATENCY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    // Capture returning read data; both beats clear on accept so an unsplit
    // access merges against zero.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_beat0 <= 32'b0;
            q_beat1 <= 32'b0;
        end else if (accept) begin
            q_beat0 <= 32'b0;
            q_beat1 <= 32'b0;
        end else if (tail_v) begin
            if (tail_b) begin
                q_beat1 <= mem_q;
            end else begin
                q_beat0 <= mem_q;
            end
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    next_state = acc_err ? S_RESP : S_BEAT0;
                end
            end
            S_BEAT0: begin
                if (split_q) begin
                    next_state = S_BEAT1;
                end else begin
                    next_state = wr_q ? S_RESP : S_WAIT;
                end
            end
`ifndef DATA_MISALIGNED_TRAP_EN
            S_BEAT1: begin
                next_state = wr_q ? S_RESP : S_WAIT;
            end
`endif
            S_WAIT: begin
                // Leave once the data of the last beat is being captured
                if (tail_v && (tail_b == split_q)) begin
                    next_state = S_RESP;
                end
            end
            S_RESP: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Merge, realign and extend the captured read beats
    always_comb begin
        q_wide      = {q_beat1, q_beat0} >> {off_q, 3'b000};
        q_lo        = q_wide[31:0];
        load_result = q_lo;
        case (fmt_q[1:0])
            2'b00:   load_result = fmt_q[2] ? {24'b0, q_lo[7:0]}
                                            : {{24{q_lo[7]}}, q_lo[7:0]};
            2'b01:   load_result = fmt_q[2] ? {16'b0, q_lo[15:0]}
                                            : {{16{q_lo[15]}}, q_lo[15:0]};
            default: load_result = q_lo;
        endcase
    end

    // Outputs decoded from state; reset forces every output to its idle value
    // so an aborted beat never writes and no response escapes.
    always_comb begin
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_data   = 32'b0;
        resp_error  = 1'b0;
        mem_address = '0;
        mem_byteena = 4'b0;
        mem_wren    = 1'b0;
        mem_data    = 32'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
            end
            S_BEAT0: begin
                mem_address = word_q;
                mem_byteena = mask_q[3:0];
                mem_wren    = wr_q;
                mem_data    = wide_q[31:0];
            end
`ifndef DATA_MISALIGNED_TRAP_EN
            S_BEAT1: begin
                mem_address = word_q + ADDR_WIDTH'(1);
                mem_byteena = mask_q[7:4];
                mem_wren    = wr_q;
                mem_data    = wide_q[63:32];
            end
`endif
            S_RESP: begin
                resp_valid = 1'b1;
                resp_error = err_q;
                resp_data  = (err_q || wr_q) ? 32'b0 : load_result;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
        if (reset) begin
            req_ready   = 1'b0;
            resp_valid  = 1'b0;
            resp_data   = 32'b0;
            resp_error  = 1'b0;
            mem_address = '0;
            mem_byteena = 4'b0;
            mem_wren    = 1'b0;
            mem_data    = 32'b0;
        end
    end

    assign debug_state = state;

    // Address bits outside the word index and the discarded merge half
    assign unused_bits = ^{rel_addr[31:ADDR_WIDTH+2], rel_addr[1:0], q_wide[63:32],
                           mask_q[7:4], wide_q[63:32]};

endmodule

// File: tb/tb_data_memory_bridge.sv
// Directed bench for data_memory_bridge. Two bridges share one request
// stream: one with MEM_LATENCY=1 and one with MEM_LATENCY=3, each with its own
// byte-enabled RAM model. Expected values are hand-computed constants.
module tb_data_memory_bridge;

    localparam logic [31:0] DB = 32'h10010000;
    localparam logic [31:0] DE = 32'h1001FFFF;

    logic clock = 1'b0;
    logic reset;
    logic req_valid;
    logic req_write;
    logic [2:0] req_format;
    logic [31:0] req_address;
    logic [31:0] req_write_data;

    logic ready_a, resp_valid_a, resp_error_a, wren_a;
    logic [31:0] resp_data_a, data_a, q_a;
    logic [13:0] addr_a;
    logic [3:0] ben_a;
    logic [2:0] dbg_a;

    logic ready_b, resp_valid_b, resp_error_b, wren_b;
    logic [31:0] resp_data_b, data_b, q_b;
    logic [13:0] addr_b;
    logic [3:0] ben_b;
    logic [2:0] dbg_b;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    // Per-request observations
    int ra_cyc, rb_cyc, ra_n, rb_n, nbeats, nbeats_b;
    logic [31:0] ra_data, rb_data;
    logic ra_err, rb_err, acc_ok, rdy_viol, rdy_after;
    int bt_cyc[4];
    logic [3:0] bt_ben[4];
    logic [31:0] bt_addr[4];
    logic bt_wren[4];
    logic [31:0] bt_data[4];

    // Clock and the RAM models
    always #5 clock = ~clock;

    bit [31:0] ram_a [0:16383];
    bit [31:0] ram_b [0:16383];
    logic [31:0] rd_a;
    logic [31:0] rd_b0, rd_b1, rd_b2;

    always @(posedge clock) begin
        for (int j = 0; j < 4; j++) begin
            if (wren_a && ben_a[j]) ram_a[addr_a][8*j +: 8] <= data_a[8*j +: 8];
            if (wren_b && ben_b[j]) ram_b[addr_b][8*j +: 8] <= data_b[8*j +: 8];
        end
        rd_a  <= ram_a[addr_a];
        rd_b0 <= ram_b[addr_b];
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
    end
    assign q_a = rd_a;
    assign q_b = rd_b2;

    data_memory_bridge #(.MEM_LATENCY(1)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready_a),
        .req_write(req_write), .req_format(req_format), .req_address(req_address),
        .req_write_data(req_write_data), .resp_valid(resp_valid_a),
        .resp_data(resp_data_a), .resp_error(resp_error_a), .mem_address(addr_a),
        .mem_byteena(ben_a), .mem_wren(wren_a), .mem_data(data_a), .mem_q(q_a),
        .debug_state(dbg_a)
    );

    data_memory_bridge #(.MEM_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready_b),
        .req_write(req_write), .req_format(req_format), .req_address(req_address),
        .req_write_data(req_write_data), .resp_valid(resp_valid_b),
        .resp_data(resp_data_b), .resp_error(resp_error_b), .mem_address(addr_b),
        .mem_byteena(ben_b), .mem_wren(wren_b), .mem_data(data_b), .mem_q(q_b),
        .debug_state(dbg_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Drive one request; cycle 0 is the accept cycle, outputs sampled on negedges
    task automatic do_req(input logic wr, input logic [2:0] fmt,
                          input logic [31:0] addr, input logic [31:0] wdata);
        @(negedge clock);
        req_write = wr;
        req_format = fmt;
        req_address = addr;
        req_write_data = wdata;
        req_valid = 1'b1;
        acc_ok = ready_a & ready_b;
        ra_cyc = -1; rb_cyc = -1; ra_n = 0; rb_n = 0;
        nbeats = 0; nbeats_b = 0; rdy_viol = 1'b0;
        ra_data = 32'hDEADBEEF; rb_data = 32'hDEADBEEF; ra_err = 1'bx; rb_err = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            req_valid = 1'b0;
            if ((ready_a && ra_cyc < 0) || (ready_b && rb_cyc < 0)) rdy_viol = 1'b1;
            if (wren_a || ben_a != 4'b0) begin
                if (nbeats < 4) begin
                    bt_cyc[nbeats] = k;
                    bt_ben[nbeats] = ben_a;
                    bt_addr[nbeats] = {18'b0, addr_a};
                    bt_wren[nbeats] = wren_a;
                    bt_data[nbeats] = data_a;
                end
                nbeats++;
            end
            if (wren_b || ben_b != 4'b0) nbeats_b++;
            if (resp_valid_a) begin
                ra_n++;
                if (ra_cyc < 0) begin
                    ra_cyc = k; ra_data = resp_data_a; ra_err = resp_error_a;
                end
            end
            if (resp_valid_b) begin
                rb_n++;
                if (rb_cyc < 0) begin
                    rb_cyc = k; rb_data = resp_data_b; rb_err = resp_error_b;
                end
            end
            if (ra_cyc >= 0 && rb_cyc >= 0) break;
        end
        @(negedge clock);
        if (resp_valid_a) ra_n++;
        if (resp_valid_b) rb_n++;
        rdy_after = ready_a & ready_b;
    endtask

    // Scoreboard: compare both responses against the queued expectation
    task automatic check_resp(input string tag, input int ea, input int eb,
                              input logic eerr, input int ebeats);
        logic [31:0] e;
        e = exp_q.pop_front();
        chk({tag, "_accept"}, 32'(acc_ok), 32'd1);
        chk({tag, "_cyc_l1"}, 32'(ra_cyc), 32'(ea));
        chk({tag, "_cyc_l3"}, 32'(rb_cyc), 32'(eb));
        chk({tag, "_data_l1"}, ra_data, e);
        chk({tag, "_data_l3"}, rb_data, e);
        chk({tag, "_err_l1"}, 32'(ra_err), 32'(eerr));
        chk({tag, "_err_l3"}, 32'(rb_err), 32'(eerr));
        chk({tag, "_pulses"}, 32'(ra_n + rb_n), 32'd2);
        chk({tag, "_busy_ready"}, 32'(rdy_viol), 32'd0);
        chk({tag, "_ready_after"}, 32'(rdy_after), 32'd1);
        chk({tag, "_beats_l1"}, 32'(nbeats), 32'(ebeats));
        chk({tag, "_beats_l3"}, 32'(nbeats_b), 32'(ebeats));
    endtask

    task automatic check_beat(input string tag, input int i, input int cyc,
                              input logic [3:0] ben, input logic [31:0] addr,
                              input logic wren, input logic [31:0] data);
        chk({tag, "_bcyc"}, 32'(bt_cyc[i]), 32'(cyc));
        chk({tag, "_bben"}, {28'b0, bt_ben[i]}, {28'b0, ben});
        chk({tag, "_baddr"}, bt_addr[i], addr);
        chk({tag, "_bwren"}, 32'(bt_wren[i]), 32'(wren));
        if (wren) chk({tag, "_bdata"}, bt_data[i], data);
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_format = 3'b0;
        req_address = 32'b0;
        req_write_data = 32'b0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(ready_a | ready_b), 32'd0);
        chk("rst_resp", 32'(resp_valid_a | resp_valid_b | resp_error_a), 32'd0);
        chk("rst_rdata", resp_data_a | resp_data_b, 32'd0);
        chk("rst_mem", {13'b0, wren_a, ben_a, addr_a}, 32'd0);
        chk("rst_mdata", data_a, 32'd0);
        chk("rst_state", {26'b0, dbg_a, dbg_b}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_ready", 32'(ready_a & ready_b), 32'd1);

        exp_q.push_back(32'h0);
        do_req(1'b1, 3'b010, DB, 32'h12345678);
        check_resp("sw_aligned", 2, 2, 1'b0, 1);
        check_beat("sw_aligned", 0, 1, 4'b1111, 32'd0, 1'b1, 32'h12345678);

        exp_q.push_back(32'h0);
        do_req(1'b1, 3'b010, DB + 2, 32'hAABBCCDD);
        check_resp("sw_split", 3, 3, 1'b0, 2);
        check_beat("sw_split0", 0, 1, 4'b1100, 32'd0, 1'b1, 32'hCCDD0000);
        check_beat("sw_split1", 1, 2, 4'b0011, 32'd1, 1'b1, 32'h0000AABB);

        exp_q.push_back(32'hAABBCCDD);
        do_req(1'b0, 3'b010, DB + 2, 32'h0);
        check_resp("lw_split", 4, 6, 1'b0, 2);
        check_beat("lw_split0", 0, 1, 4'b1100, 32'd0, 1'b0, 32'h0);
        check_beat("lw_split1", 1, 2, 4'b0011, 32'd1, 1'b0, 32'h0);

        exp_q.push_back(32'hFFFFFFCC);
        do_req(1'b0, 3'b000, DB + 3, 32'h0);
        check_resp("lb", 3, 5, 1'b0, 1);
        check_beat("lb", 0, 1, 4'b1000, 32'd0, 1'b0, 32'h0);

        exp_q.push_back(32'h000000CC);
        do_req(1'b0, 3'b100, DB + 3, 32'h0);
        check_resp("lbu", 3, 5, 1'b0, 1);

        exp_q.push_back(32'hFFFFBBCC);
        do_req(1'b0, 3'b001, DB + 3, 32'h0);
        check_resp("lh_split", 4, 6, 1'b0, 2);
        check_beat("lh_split0", 0, 1, 4'b1000, 32'd0, 1'b0, 32'h0);
        check_beat("lh_split1", 1, 2, 4'b0001, 32'd1, 1'b0, 32'h0);

        exp_q.push_back(32'h0);
        do_req(1'b1, 3'b000, DB + 1, 32'h000001FF);
        check_resp("sb", 2, 2, 1'b0, 1);
        check_beat("sb", 0, 1, 4'b0010, 32'd0, 1'b1, 32'h0001FF00);

        exp_q.push_back(32'hFFFFFFFF);
        do_req(1'b0, 3'b000, DB + 1, 32'h0);
        check_resp("lb_ff", 3, 5, 1'b0, 1);

        exp_q.push_back(32'h0000FF78);
        do_req(1'b0, 3'b101, DB, 32'h0);
        check_resp("lhu", 3, 5, 1'b0, 1);

        exp_q.push_back(32'h0);
        do_req(1'b0, 3'b010, DE - 3, 32'h0);
        check_resp("lw_top", 3, 5, 1'b0, 1);
        check_beat("lw_top", 0, 1, 4'b1111, 32'h3FFF, 1'b0, 32'h0);

        exp_q.push_back(32'h0);
        do_req(1'b0, 3'b100, DE, 32'h0);
        check_resp("lbu_end", 3, 5, 1'b0, 1);
        check_beat("lbu_end", 0, 1, 4'b1000, 32'h3FFF, 1'b0, 32'h0);

        exp_q.push_back(32'h0);
        do_req(1'b1, 3'b010, DE - 1, 32'hFFFFFFFF);
        check_resp("sw_cross_end", 1, 1, 1'b1, 0);

        exp_q.push_back(32'h0);
        do_req(1'b0, 3'b010, 32'h0, 32'h0);
        check_resp("lw_zero", 1, 1, 1'b1, 0);

        exp_q.push_back(32'h0);
        do_req(1'b0, 3'b000, DB - 1, 32'h0);
        check_resp("lb_below", 1, 1, 1'b1, 0);

        exp_q.push_back(32'h0);
        do_req(1'b0, 3'b011, DB, 32'h0);
        check_resp("fmt_bad", 1, 1, 1'b1, 0);

        exp_q.push_back(32'hCCDDFF78);
        do_req(1'b0, 3'b010, DB, 32'h0);
        check_resp("lw_aligned", 3, 5, 1'b0, 1);

        // Reset during the second beat of a split store
        @(negedge clock);
        req_write = 1'b1;
        req_format = 3'b010;
        req_address = DB + 1;
        req_write_data = 32'h11223344;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("rst_mid_beat0", {27'b0, wren_a, ben_a}, {27'b0, 1'b1, 4'b1110});
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_nowren", 32'(wren_a | wren_b), 32'd0);
        chk("rst_mid_noben", {24'b0, ben_a, ben_b}, 32'd0);
        chk("rst_mid_noresp", 32'(resp_valid_a | resp_valid_b), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_ready", 32'(ready_a & ready_b), 32'd1);
        chk("rst_mid_resp_after", 32'(resp_valid_a | resp_valid_b), 32'd0);
        repeat (3) begin
            @(negedge clock);
            chk("rst_mid_quiet", 32'(resp_valid_a | resp_valid_b | wren_a | wren_b), 32'd0);
        end

        exp_q.push_back(32'h22334478);
        do_req(1'b0, 3'b010, DB, 32'h0);
        check_resp("rst_mid_word0", 3, 5, 1'b0, 1);

        exp_q.push_back(32'h0000AABB);
        do_req(1'b0, 3'b010, DB + 4, 32'h0);
        check_resp("rst_mid_word1", 3, 5, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
